// File: rtl/pix_stream_tx_if.sv
// Byte stream from an upstream source (valid/ready).
// master: source drives valid/data; slave: sink drives ready.
interface pix_stream_tx_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/pix_stream_tx.sv
// Paces an upstream byte stream into one framed pixel-strobe frame.
// Ports: sys_clk, sys_rst (async, high), start, up (valid/ready bytes),
// po_flag/po_data/po_sof/po_eol pixel out, busy, frame_done, underrun.
module pix_stream_tx #(
   parameter logic [9:0] COL_MAX   = 10'd99,
   parameter logic [9:0] ROW_MAX   = 10'd99,
   parameter logic [7:0] PIX_GAP   = 8'd1,
   parameter logic [7:0] LINE_GAP  = 8'd4,
   parameter logic [7:0] FRAME_GAP = 8'd16
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic           start,
   pix_stream_tx_if.slave up,
   output logic           po_flag,
   output logic [7:0]     po_data,
   output logic           po_sof,
   output logic           po_eol,
   output logic           busy,
   output logic           frame_done,
   output logic           underrun
);

   typedef enum logic [2:0] {
      IDLE,
      PIX,
      GAP,
      LGAP,
      FGAP
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] col_q, col_d;
   logic [9:0] row_q, row_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] data_q, data_d;
   logic       flag_q, flag_d;
   logic       sof_q, sof_d;
   logic       eol_q, eol_d;
   logic       done_q, done_d;
   logic       urun_q, urun_d;
   logic       xfer;

   // ready depends on state only, never on in_valid
   assign up.in_ready = (state_q == PIX);
   assign xfer        = up.in_valid && (state_q == PIX);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      gap_d   = gap_q;
      data_d  = data_q;
      flag_d  = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      done_d  = 1'b0;
      urun_d  = urun_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PIX;
               urun_d  = 1'b0;
            end
         end
         PIX: begin
            if (xfer) begin
               flag_d = 1'b1;
               data_d = up.in_data;
               sof_d  = (col_q == 10'd0) && (row_q == 10'd0);
               eol_d  = (col_q == COL_MAX);
               if (col_q != COL_MAX) begin
                  col_d = col_q + 10'd1;
                  if (PIX_GAP != 8'd0) begin
                     state_d = GAP;
                     gap_d   = PIX_GAP;
                  end
               end else if (row_q != ROW_MAX) begin
                  // line gap takes the place of the pixel gap
                  col_d = 10'd0;
                  row_d = row_q + 10'd1;
                  if (LINE_GAP != 8'd0) begin
                     state_d = LGAP;
                     gap_d   = LINE_GAP;
                  end
               end else begin
                  col_d = 10'd0;
                  row_d = 10'd0;
                  if (FRAME_GAP != 8'd0) begin
                     state_d = FGAP;
                     gap_d   = FRAME_GAP;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end else if ((col_q != 10'd0) || (row_q != 10'd0)) begin
               // waiting before the first pixel is not a starvation
               urun_d = 1'b1;
            end
         end
         GAP, LGAP: begin
            if (gap_q <= 8'd1) begin
               state_d = PIX;
               gap_d   = 8'd0;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         FGAP: begin
            if (gap_q <= 8'd1) begin
               state_d = IDLE;
               gap_d   = 8'd0;
               done_d  = 1'b1;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         col_q   <= 10'd0;
         row_q   <= 10'd0;
         gap_q   <= 8'd0;
         data_q  <= 8'd0;
         flag_q  <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         done_q  <= 1'b0;
         urun_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         done_q  <= done_d;
         urun_q  <= urun_d;
      end
   end

   assign po_flag    = flag_q;
   assign po_data    = data_q;
   assign po_sof     = sof_q;
   assign po_eol     = eol_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign underrun   = urun_q;

endmodule

// File: tb/tb_pix_stream_tx.sv
// Bench for pix_stream_tx: per-cycle vector tables on small geometries
// plus a full default-size frame with event counting.
module tb_pix_stream_tx;

   typedef struct {
      logic       st;
      logic       vld;
      logic       rst;
      logic       flag;
      logic [7:0] data;
      logic       sof;
      logic       eol;
      logic       busy;
      logic       done;
      logic       urun;
   } vec_t;

   vec_t tv [64];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] src_cnt = 8'd0;
   logic       xfer_pend = 1'b0;
   int         sel = 1;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   pix_stream_tx_if if1 ();
   pix_stream_tx_if if2 ();
   pix_stream_tx_if if3 ();

   assign if1.in_valid = valid;
   assign if2.in_valid = valid;
   assign if3.in_valid = valid;
   assign if1.in_data  = src_cnt;
   assign if2.in_data  = src_cnt;
   assign if3.in_data  = src_cnt;

   logic st1, st2, st3;
   assign st1 = start && (sel == 1);
   assign st2 = start && (sel == 2);
   assign st3 = start && (sel == 3);

   logic       fl1, so1, eo1, bu1, dn1, ur1;
   logic       fl2, so2, eo2, bu2, dn2, ur2;
   logic       fl3, so3, eo3, bu3, dn3, ur3;
   logic [7:0] dt1, dt2, dt3;
   logic [13:0] out1, out2, out3, act;
   logic        rdy;

   pix_stream_tx #(
      .COL_MAX(10'd3), .ROW_MAX(10'd1),
      .PIX_GAP(8'd1), .LINE_GAP(8'd3), .FRAME_GAP(8'd2)
   ) u1 (
      .sys_clk(clk), .sys_rst(rst), .start(st1), .up(if1),
      .po_flag(fl1), .po_data(dt1), .po_sof(so1), .po_eol(eo1),
      .busy(bu1), .frame_done(dn1), .underrun(ur1)
   );

   pix_stream_tx #(
      .COL_MAX(10'd3), .ROW_MAX(10'd1),
      .PIX_GAP(8'd0), .LINE_GAP(8'd0), .FRAME_GAP(8'd0)
   ) u2 (
      .sys_clk(clk), .sys_rst(rst), .start(st2), .up(if2),
      .po_flag(fl2), .po_data(dt2), .po_sof(so2), .po_eol(eo2),
      .busy(bu2), .frame_done(dn2), .underrun(ur2)
   );

   pix_stream_tx u3 (
      .sys_clk(clk), .sys_rst(rst), .start(st3), .up(if3),
      .po_flag(fl3), .po_data(dt3), .po_sof(so3), .po_eol(eo3),
      .busy(bu3), .frame_done(dn3), .underrun(ur3)
   );

   assign out1 = {fl1, dt1, so1, eo1, bu1, dn1, ur1};
   assign out2 = {fl2, dt2, so2, eo2, bu2, dn2, ur2};
   assign out3 = {fl3, dt3, so3, eo3, bu3, dn3, ur3};

   always_comb begin
      act = out1;
      rdy = if1.in_ready;
      if (sel == 2) begin
         act = out2;
         rdy = if2.in_ready;
      end else if (sel == 3) begin
         act = out3;
         rdy = if3.in_ready;
      end
   end

   task automatic clr_tab();
      for (int i = 0; i < 64; i++) begin
         tv[i].st   = 1'b0;
         tv[i].vld  = 1'b1;
         tv[i].rst  = 1'b0;
         tv[i].flag = 1'b0;
         tv[i].data = 8'd0;
         tv[i].sof  = 1'b0;
         tv[i].eol  = 1'b0;
         tv[i].busy = 1'b0;
         tv[i].done = 1'b0;
         tv[i].urun = 1'b0;
      end
   endtask

   task automatic pix(input int c, input logic [7:0] d,
                      input logic s, input logic e);
      tv[c].flag = 1'b1;
      tv[c].data = d;
      tv[c].sof  = s;
      tv[c].eol  = e;
   endtask

   task automatic busy_rng(input int a, input int b);
      for (int i = a; i <= b; i++) tv[i].busy = 1'b1;
   endtask

   task automatic urun_rng(input int a, input int b);
      for (int i = a; i <= b; i++) tv[i].urun = 1'b1;
   endtask

   // po_data holds between strobes and clears under reset
   task automatic fin_tab();
      for (int i = 1; i < 64; i++) begin
         if (tv[i].rst) tv[i].data = 8'd0;
         else if (!tv[i].flag) tv[i].data = tv[i-1].data;
      end
   endtask

   // Standard case-1 frame starting at cycle 0
   task automatic frame1();
      pix(2, 8'd0, 1'b1, 1'b0);
      pix(4, 8'd1, 1'b0, 1'b0);
      pix(6, 8'd2, 1'b0, 1'b0);
      pix(8, 8'd3, 1'b0, 1'b1);
      pix(12, 8'd4, 1'b0, 1'b0);
      pix(14, 8'd5, 1'b0, 1'b0);
      pix(16, 8'd6, 1'b0, 1'b0);
      pix(18, 8'd7, 1'b0, 1'b1);
      busy_rng(1, 19);
      tv[20].done = 1'b1;
   endtask

   // One cycle: inputs driven just after posedge, outputs sampled at negedge
   task automatic step(input logic s, input logic v, input logic r);
      @(posedge clk);
      #1;
      if (xfer_pend) src_cnt = src_cnt + 8'd1;
      xfer_pend = 1'b0;
      rst   = r;
      start = s;
      valid = v;
      if (r) src_cnt = 8'd0;
      @(negedge clk);
      xfer_pend = valid && rdy && !rst;
   endtask

   task automatic do_reset(input int which);
      sel       = which;
      rst       = 1'b1;
      start     = 1'b0;
      valid     = 1'b0;
      src_cnt   = 8'd0;
      xfer_pend = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== 14'd0) begin
         errors++;
         $display("FAIL reset sel%0d got %b want %b", which, act, 14'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_tab(input string name, input int n);
      logic [13:0] exp;
      for (int c = 0; c < n; c++) begin
         step(tv[c].st, tv[c].vld, tv[c].rst);
         exp = {tv[c].flag, tv[c].data, tv[c].sof, tv[c].eol,
                tv[c].busy, tv[c].done, tv[c].urun};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %b want %b", name, c, act, exp);
         end
      end
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      int n_flag, n_eol, n_sof, n_done, n_derr, cyc;
      logic [7:0] exp_d;
      logic done_seen;

      // Case 1: nominal small frame
      do_reset(1);
      clr_tab();
      tv[0].st = 1'b1;
      frame1();
      fin_tab();
      run_tab("nominal", 24);

      // Case 2: all gaps zero
      do_reset(2);
      clr_tab();
      tv[0].st = 1'b1;
      for (int i = 0; i < 8; i++)
         pix(2 + i, 8'(i), (i == 0), (i == 3) || (i == 7));
      busy_rng(1, 8);
      tv[9].done = 1'b1;
      fin_tab();
      run_tab("nogap", 13);

      // Case 3: source stall mid-line, underrun sticky until next start
      do_reset(1);
      clr_tab();
      tv[0].st  = 1'b1;
      tv[24].st = 1'b1;
      tv[5].vld = 1'b0;
      tv[6].vld = 1'b0;
      pix(2, 8'd0, 1'b1, 1'b0);
      pix(4, 8'd1, 1'b0, 1'b0);
      pix(8, 8'd2, 1'b0, 1'b0);
      pix(10, 8'd3, 1'b0, 1'b1);
      pix(14, 8'd4, 1'b0, 1'b0);
      pix(16, 8'd5, 1'b0, 1'b0);
      pix(18, 8'd6, 1'b0, 1'b0);
      pix(20, 8'd7, 1'b0, 1'b1);
      busy_rng(1, 21);
      tv[22].done = 1'b1;
      urun_rng(6, 24);
      busy_rng(25, 29);
      pix(26, 8'd8, 1'b1, 1'b0);
      pix(28, 8'd9, 1'b0, 1'b0);
      fin_tab();
      run_tab("stall", 30);

      // Case 4a: start re-pulsed mid-frame is ignored
      do_reset(1);
      clr_tab();
      tv[0].st  = 1'b1;
      tv[10].st = 1'b1;
      frame1();
      fin_tab();
      run_tab("repulse", 24);

      // Case 4b: start held, frames back to back
      do_reset(1);
      clr_tab();
      for (int i = 0; i <= 30; i++) tv[i].st = 1'b1;
      frame1();
      busy_rng(21, 30);
      pix(22, 8'd8, 1'b1, 1'b0);
      pix(24, 8'd9, 1'b0, 1'b0);
      pix(26, 8'd10, 1'b0, 1'b0);
      pix(28, 8'd11, 1'b0, 1'b1);
      fin_tab();
      run_tab("held", 31);

      // Case 5: async reset mid-frame, then a fresh frame
      do_reset(1);
      clr_tab();
      tv[0].st  = 1'b1;
      tv[17].st = 1'b1;
      tv[13].rst = 1'b1;
      tv[14].rst = 1'b1;
      pix(2, 8'd0, 1'b1, 1'b0);
      pix(4, 8'd1, 1'b0, 1'b0);
      pix(6, 8'd2, 1'b0, 1'b0);
      pix(8, 8'd3, 1'b0, 1'b1);
      pix(12, 8'd4, 1'b0, 1'b0);
      busy_rng(1, 12);
      pix(19, 8'd0, 1'b1, 1'b0);
      pix(21, 8'd1, 1'b0, 1'b0);
      pix(23, 8'd2, 1'b0, 1'b0);
      pix(25, 8'd3, 1'b0, 1'b1);
      pix(29, 8'd4, 1'b0, 1'b0);
      pix(31, 8'd5, 1'b0, 1'b0);
      pix(33, 8'd6, 1'b0, 1'b0);
      pix(35, 8'd7, 1'b0, 1'b1);
      busy_rng(18, 36);
      tv[37].done = 1'b1;
      fin_tab();
      run_tab("midrst", 40);

      // Case 6: default geometry, full frame counted
      do_reset(3);
      n_flag = 0;
      n_eol  = 0;
      n_sof  = 0;
      n_done = 0;
      n_derr = 0;
      exp_d  = 8'd0;
      done_seen = 1'b0;
      cyc = 0;
      step(1'b1, 1'b1, 1'b0);
      while (!done_seen && cyc < 25000) begin
         step(1'b0, 1'b1, 1'b0);
         cyc++;
         if (fl3) begin
            n_flag++;
            if (dt3 !== exp_d) n_derr++;
            exp_d = exp_d + 8'd1;
         end
         if (eo3) n_eol++;
         if (so3) n_sof++;
         if (ur3) n_derr++;
         if (dn3) begin
            n_done++;
            done_seen = 1'b1;
         end
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL full_timeout got no frame_done in %0d cycles", cyc);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (fl3) n_flag++;
         if (dn3) n_done++;
      end
      chk("full_flags", n_flag, 10000);
      chk("full_eol", n_eol, 100);
      chk("full_sof", n_sof, 1);
      chk("full_done", n_done, 1);
      chk("full_data_err", n_derr, 0);
      chk("full_busy_end", int'(bu3), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
